// File: rtl/avalon_ahb_bridge.sv
// Avalon-MM slave to AHB-Lite master bridge: one outstanding single transfer, byteenable -> HSIZE/HADDR[1:0].
// Define AVL_AHB_BRIDGE_WRSP_EN to add a writeresponsevalid output reporting write completion status.
module avalon_ahb_bridge #(
  parameter int         AW        = 32,
  parameter int         DW        = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic [3:0]    byteenable,
  input  logic          read,
  input  logic          write,
  input  logic [DW-1:0] writedata,
  output logic          waitrequest,
  output logic [DW-1:0] readdata,
  output logic          readdatavalid,
  output logic [1:0]    response,
`ifdef AVL_AHB_BRIDGE_WRSP_EN
  output logic          writeresponsevalid,
`endif
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [3:0]    HPROT,
  output logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic [DW-1:0] HRDATA,
  input  logic          HRESP
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] RSP_OKAY  = 2'b00;
  localparam logic [1:0] RSP_SLVER = 2'b10;

  // Returns {legal, hsize[2:0], addr_lo[1:0]} for a byte-lane pattern.
  function automatic logic [5:0] be_map(input logic [3:0] be);
    case (be)
      4'b1111: be_map = {1'b1, 3'd2, 2'b00};
      4'b0011: be_map = {1'b1, 3'd1, 2'b00};
      4'b1100: be_map = {1'b1, 3'd1, 2'b10};
      4'b0001: be_map = {1'b1, 3'd0, 2'b00};
      4'b0010: be_map = {1'b1, 3'd0, 2'b01};
      4'b0100: be_map = {1'b1, 3'd0, 2'b10};
      4'b1000: be_map = {1'b1, 3'd0, 2'b11};
      default: be_map = 6'b000000;
    endcase
  endfunction

  state_t        r_state;
  logic [1:0]    r_htrans;
  logic [AW-1:0] r_haddr;
  logic          r_hwrite;
  logic [2:0]    r_hsize;
  logic [DW-1:0] r_hwdata;
  logic [DW-1:0] r_rdata;
  logic          r_rdvalid;
  logic [1:0]    r_resp;
  logic          r_pend_rd;
`ifdef AVL_AHB_BRIDGE_WRSP_EN
  logic          r_pend_wr;
  logic          r_wrvalid;
`endif

  logic [5:0] w_map;
  logic       w_req;
  logic       w_legal;
  logic       w_unused_addr;

  assign w_map   = be_map(byteenable);
  assign w_req   = read | write;
  assign w_legal = w_map[5] & ~(read & write);
  // The byte offset comes from byteenable; the low address bits are ignored.
  assign w_unused_addr = ^address[1:0];

  assign waitrequest   = reset | (r_state != S_IDLE);
  assign readdata      = r_rdata;
  assign readdatavalid = r_rdvalid;
  assign response      = r_resp;
  assign HADDR         = r_haddr;
  assign HTRANS        = r_htrans;
  assign HWRITE        = r_hwrite;
  assign HSIZE         = r_hsize;
  assign HBURST        = 3'b000;
  assign HPROT         = HPROT_VAL;
  assign HWDATA        = r_hwdata;
`ifdef AVL_AHB_BRIDGE_WRSP_EN
  assign writeresponsevalid = r_wrvalid;
`endif

  // Transfer sequencer with registered AHB and Avalon response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_htrans  <= TR_IDLE;
      r_haddr   <= {AW{1'b0}};
      r_hwrite  <= 1'b0;
      r_hsize   <= 3'd0;
      r_hwdata  <= {DW{1'b0}};
      r_rdata   <= {DW{1'b0}};
      r_rdvalid <= 1'b0;
      r_resp    <= RSP_OKAY;
      r_pend_rd <= 1'b0;
`ifdef AVL_AHB_BRIDGE_WRSP_EN
      r_pend_wr <= 1'b0;
      r_wrvalid <= 1'b0;
`endif
    end else begin
      r_rdvalid <= 1'b0;
`ifdef AVL_AHB_BRIDGE_WRSP_EN
      r_wrvalid <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_pend_rd <= read;
`ifdef AVL_AHB_BRIDGE_WRSP_EN
            r_pend_wr <= write;
`endif
            if (w_legal) begin
              r_state  <= S_ADDR;
              r_htrans <= TR_NONSEQ;
              r_haddr  <= {address[AW-1:2], w_map[1:0]};
              r_hsize  <= w_map[4:2];
              r_hwrite <= write;
              if (write) begin
                r_hwdata <= writedata;
              end
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            r_state  <= S_DATA;
            r_htrans <= TR_IDLE;
          end
        end
        S_DATA: begin
          // A two-cycle error simply extends this wait; status is taken on the ready edge.
          if (HREADY) begin
            r_state <= S_IDLE;
            if (!r_hwrite) begin
              r_rdvalid <= 1'b1;
              r_rdata   <= HRDATA;
              r_resp    <= HRESP ? RSP_SLVER : RSP_OKAY;
            end
`ifdef AVL_AHB_BRIDGE_WRSP_EN
            else begin
              r_wrvalid <= 1'b1;
              r_resp    <= HRESP ? RSP_SLVER : RSP_OKAY;
            end
`endif
          end
        end
        S_ERR: begin
          r_state <= S_IDLE;
          if (r_pend_rd) begin
            r_rdvalid <= 1'b1;
            r_rdata   <= {DW{1'b0}};
            r_resp    <= RSP_SLVER;
          end
`ifdef AVL_AHB_BRIDGE_WRSP_EN
          if (r_pend_wr) begin
            r_wrvalid <= 1'b1;
            r_resp    <= RSP_SLVER;
          end
`endif
        end
        default: begin
          r_state  <= S_IDLE;
          r_htrans <= TR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_ahb_bridge.sv
// Bench for avalon_ahb_bridge: whole run is planned up front as per-cycle timelines, then checked every cycle.
module tb_avalon_ahb_bridge;

  localparam int N = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read, write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [1:0]  response;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;
`ifdef AVL_AHB_BRIDGE_WRSP_EN
  logic        writeresponsevalid;
`endif

  avalon_ahb_bridge dut (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid), .response(response),
`ifdef AVL_AHB_BRIDGE_WRSP_EN
    .writeresponsevalid(writeresponsevalid),
`endif
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  // Stimulus schedule, indexed by cycle.
  logic        s_rst [N];
  logic        s_rd [N];
  logic        s_wr [N];
  logic [31:0] s_addr [N];
  logic [3:0]  s_be [N];
  logic [31:0] s_wd [N];
  logic        s_hrdy [N];
  logic [31:0] s_hrd [N];
  logic        s_hresp [N];
  // Expected outputs, indexed by cycle.
  logic        e_wait [N];
  logic [1:0]  e_trans [N];
  logic        e_rdv [N];
  logic        e_wrv [N];
  logic [31:0] e_haddr [N];
  logic [2:0]  e_hsize [N];
  logic        e_hwrite [N];
  logic        e_hwd_chk [N];
  logic [31:0] e_hwd [N];
  logic [31:0] e_rdata [N];
  logic [1:0]  e_resp [N];

  int cyc = 0;
  int t_end = N - 1;
  bit run_cmp = 1'b0;
  int n_checks = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
    end
  endtask

  // Legal lanes are a contiguous, naturally aligned run of 1, 2 or 4 bytes.
  task automatic be_decode(input logic [3:0] be, output logic ok, output logic [2:0] sz, output logic [1:0] lo);
    int n, low;
    n = $countones(be);
    low = 0;
    for (int i = 3; i >= 0; i--) if (be[i]) low = i;
    ok = 1'b0;
    if (n == 1 || n == 2 || n == 4)
      if ((low % n) == 0 && be == 4'(((1 << n) - 1) << low)) ok = 1'b1;
    sz = (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
    lo = 2'(low);
  endtask

  task automatic plan_txn(input logic rd, input logic wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int aw, input int dw, input logic err,
                          input logic [31:0] rdat, input int t, output int t_next);
    logic ok;
    logic [2:0] sz;
    logic [1:0] lo;
    int d0, e;
    s_rd[t] = rd; s_wr[t] = wr; s_addr[t] = addr; s_be[t] = be; s_wd[t] = wd;
    be_decode(be, ok, sz, lo);
    if (!ok || (rd && wr)) begin
      e_wait[t+1] = 1'b1;
      e = t + 2;
      if (rd) begin e_rdv[e] = 1'b1; e_rdata[e] = 32'h0; e_resp[e] = 2'b10; end
      if (wr) begin e_wrv[e] = 1'b1; e_resp[e] = 2'b10; end
    end else begin
      for (int c = t + 1; c <= t + 1 + aw; c++) begin
        e_wait[c] = 1'b1; e_trans[c] = 2'b10;
        e_haddr[c] = {addr[31:2], lo}; e_hsize[c] = sz; e_hwrite[c] = wr;
        s_hrdy[c] = (c == t + 1 + aw);
      end
      d0 = t + 2 + aw;
      for (int c = d0; c <= d0 + dw; c++) begin
        e_wait[c] = 1'b1; e_trans[c] = 2'b00;
        s_hrdy[c] = (c == d0 + dw);
        if (wr) begin e_hwd_chk[c] = 1'b1; e_hwd[c] = wd; end
      end
      if (err) begin
        s_hresp[d0 + dw] = 1'b1;
        if (dw > 0) s_hresp[d0 + dw - 1] = 1'b1;
      end
      e = d0 + dw + 1;
      if (rd) begin
        s_hrd[d0 + dw] = rdat;
        e_rdv[e] = 1'b1; e_rdata[e] = rdat; e_resp[e] = err ? 2'b10 : 2'b00;
      end else begin
        e_wrv[e] = 1'b1; e_resp[e] = err ? 2'b10 : 2'b00;
      end
    end
    t_next = e;
  endtask

  task automatic drive(input int c);
    reset = s_rst[c]; read = s_rd[c]; write = s_wr[c]; address = s_addr[c];
    byteenable = s_be[c]; writedata = s_wd[c]; HREADY = s_hrdy[c]; HRDATA = s_hrd[c]; HRESP = s_hresp[c];
  endtask

  // Per-cycle comparison against the planned timeline.
  always @(negedge clk) begin
    if (run_cmp && cyc >= 1 && cyc < t_end) begin
      chk("waitrequest", 32'(waitrequest), 32'(e_wait[cyc]));
      chk("HTRANS", 32'(HTRANS), 32'(e_trans[cyc]));
      chk("readdatavalid", 32'(readdatavalid), 32'(e_rdv[cyc]));
      if (e_trans[cyc] == 2'b10) begin
        chk("HADDR", HADDR, e_haddr[cyc]);
        chk("HSIZE", 32'(HSIZE), 32'(e_hsize[cyc]));
        chk("HWRITE", 32'(HWRITE), 32'(e_hwrite[cyc]));
        chk("HBURST", 32'(HBURST), 32'h0);
        chk("HPROT", 32'(HPROT), 32'h3);
      end
      if (e_hwd_chk[cyc]) chk("HWDATA", HWDATA, e_hwd[cyc]);
      if (e_rdv[cyc]) chk("readdata", readdata, e_rdata[cyc]);
`ifdef AVL_AHB_BRIDGE_WRSP_EN
      chk("writeresponsevalid", 32'(writeresponsevalid), 32'(e_wrv[cyc]));
      if (e_rdv[cyc] || e_wrv[cyc]) chk("response", 32'(response), 32'(e_resp[cyc]));
`else
      if (e_rdv[cyc]) chk("response", 32'(response), 32'(e_resp[cyc]));
`endif
    end
  end

  initial begin
    int t, t0, tb2, d0, gap, kind, aw, dw;
    logic [3:0] legal_be [7];
    logic [3:0] be;
    logic err;
    legal_be = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
    for (int i = 0; i < N; i++) begin
      s_rst[i] = 1'b0; s_rd[i] = 1'b0; s_wr[i] = 1'b0; s_addr[i] = $urandom; s_be[i] = 4'($urandom);
      s_wd[i] = $urandom; s_hrdy[i] = 1'b1; s_hrd[i] = $urandom; s_hresp[i] = 1'b0;
      e_wait[i] = 1'b0; e_trans[i] = 2'b00; e_rdv[i] = 1'b0; e_wrv[i] = 1'b0; e_haddr[i] = 32'h0;
      e_hsize[i] = 3'd0; e_hwrite[i] = 1'b0; e_hwd_chk[i] = 1'b0; e_hwd[i] = 32'h0;
      e_rdata[i] = 32'h0; e_resp[i] = 2'b00;
    end
    for (int i = 0; i <= 2; i++) begin s_rst[i] = 1'b1; e_wait[i] = 1'b1; end

    t0 = 4;
    plan_txn(1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, t0, t);
    chk("model_rdv_n3", 32'(e_rdv[t0+3]), 32'h1);
    chk("model_rdata", e_rdata[t0+3], 32'hDEAD_BEEF);
    chk("model_haddr_word", e_haddr[t0+1], 32'h0000_1004);
    chk("model_hsize_word", 32'(e_hsize[t0+1]), 32'h2);
    chk("model_one_nonseq", 32'(e_trans[t0+2]), 32'h0);
    t0 = t + 1;
    plan_txn(1'b0, 1'b1, 32'h0000_2000, 4'b0100, 32'h00AB_0000, 0, 2, 1'b0, 32'h0, t0, t);
    chk("model_haddr_byte", e_haddr[t0+1], 32'h0000_2002);
    chk("model_hsize_byte", 32'(e_hsize[t0+1]), 32'h0);
    chk("model_wait_hold", 32'(e_wait[t0+4]), 32'h1);
    t0 = t + 2;
    plan_txn(1'b1, 1'b0, 32'h0000_3000, 4'b1100, 32'h0, 0, 1, 1'b1, 32'h1234_5678, t0, t);
    chk("model_haddr_half", e_haddr[t0+1], 32'h0000_3002);
    chk("model_resp_err", 32'(e_resp[t0+4]), 32'h2);
    t0 = t + 1;
    plan_txn(1'b1, 1'b0, 32'h0000_5000, 4'b0101, 32'h0, 0, 0, 1'b0, 32'h0, t0, t);
    chk("model_illegal_rdv", 32'(e_rdv[t0+2]), 32'h1);
    plan_txn(1'b1, 1'b1, 32'h0000_6000, 4'hF, 32'h5555_AAAA, 0, 0, 1'b0, 32'h0, t, t);
    tb2 = t + 1;
    plan_txn(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 0, 1'b0, 32'hA5A5_0010, tb2, t);
    plan_txn(1'b1, 1'b0, 32'h0000_0014, 4'hF, 32'h0, 0, 0, 1'b0, 32'hA5A5_0014, t, t);
    chk("model_b2b_gap", 32'(e_trans[tb2+4]), 32'h2);
    t0 = t + 1;
    plan_txn(1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0, 0, 4, 1'b0, 32'h0, t0, t);
    d0 = t0 + 2;
    for (int c = d0 + 1; c <= d0 + 6; c++) begin
      e_wait[c] = (c <= d0 + 2); e_trans[c] = 2'b00; e_rdv[c] = 1'b0; e_wrv[c] = 1'b0;
      e_hwd_chk[c] = 1'b0; s_hrdy[c] = 1'b1; s_hresp[c] = 1'b0;
    end
    s_rst[d0+1] = 1'b1; s_rst[d0+2] = 1'b1;
    plan_txn(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0BAD_F00D, d0 + 4, t);

    for (int k = 0; k < 60; k++) begin
      gap = $urandom_range(0, 2);
      t = t + gap;
      kind = $urandom_range(0, 9);
      be = ($urandom_range(0, 9) < 7) ? legal_be[$urandom_range(0, 6)] : 4'($urandom);
      aw = $urandom_range(0, 2);
      dw = $urandom_range(0, 3);
      err = ($urandom_range(0, 3) == 0);
      if (err && dw == 0) dw = 1;
      plan_txn(kind <= 5, (kind == 0) || (kind >= 6), $urandom, be, $urandom, aw, dw, err, $urandom, t, t);
    end
    t_end = t + 6;
    run_cmp = 1'b1;

    fork
      begin
        drive(0);
        forever begin
          @(posedge clk);
          #1;
          if (cyc < N) drive(cyc);
        end
      end
    join_none

    @(negedge clk);
    chk("rst_waitrequest", 32'(waitrequest), 32'h1);
    chk("rst_HTRANS", 32'(HTRANS), 32'h0);
    chk("rst_HWRITE", 32'(HWRITE), 32'h0);
    chk("rst_HADDR", HADDR, 32'h0);
    chk("rst_HSIZE", 32'(HSIZE), 32'h0);
    chk("rst_HWDATA", HWDATA, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_readdatavalid", 32'(readdatavalid), 32'h0);
    chk("rst_response", 32'(response), 32'h0);

    while (cyc < t_end) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/avalon_ahb_bridge.md
Name: avalon_ahb_bridge

Overview:
- Avalon-MM slave to AHB-Lite master bridge, the reverse direction of the existing AHB-to-Avalon bridge.
- Lets Qsys-side masters (DMA, debug, peripheral masters) reach AHB-Lite slaves such as SCR1-side TCM/IPIC regions.
- One outstanding transfer; single (non-burst) AHB transfers only; byteenable is converted to HSIZE and HADDR[1:0].

Parameters:
- AW, 32, address width on both sides.
- DW, 32, data width; only 32 is supported.
- HPROT_VAL, 4'b0011, constant HPROT driven on every transfer (data, privileged).

Ports:
- clk  in  1  single clock for both sides
- reset  in  1  asynchronous, active-high reset
- address  in  AW  Avalon byte address
- byteenable  in  4  Avalon byte lanes
- read  in  1  Avalon read request
- write  in  1  Avalon write request
- writedata  in  DW  Avalon write data, lane-aligned
- waitrequest  out  1  Avalon stall
- readdata  out  DW  read data
- readdatavalid  out  1  read data strobe
- response  out  2  00 OKAY, 10 SLVERR
- HADDR  out  AW  AHB address
- HTRANS  out  2  IDLE=00 / NONSEQ=10
- HWRITE  out  1  AHB direction
- HSIZE  out  3  AHB size
- HBURST  out  3  constant 000 (SINGLE)
- HPROT  out  4  constant HPROT_VAL
- HWDATA  out  DW  AHB write data
- HREADY  in  1  AHB ready
- HRDATA  in  DW  AHB read data
- HRESP  in  1  AHB error

Behaviour:
- Reset values: state IDLE, HTRANS=00, HWRITE=0, HADDR=0, HSIZE=0, HWDATA=0, readdata=0, readdatavalid=0, response=00. waitrequest=1 while reset is high.
- waitrequest = (state != IDLE). A command is accepted in the IDLE cycle where read|write=1. The bridge latches address, byteenable, writedata and direction in that cycle.
- Byteenable map (legal):
  - 1111 -> HSIZE=2, addr[1:0]=00
  - 0011 -> HSIZE=1, addr[1:0]=00
  - 1100 -> HSIZE=1, addr[1:0]=10
  - 0001 / 0010 / 0100 / 1000 -> HSIZE=0, addr[1:0]=00 / 01 / 10 / 11
  - HADDR = {address[AW-1:2], mapped[1:0]}.
- Illegal commands: any other byteenable, or read and write asserted together. These go to state ERR and never produce an AHB transfer.
- States:
  - IDLE: accept a command; legal -> ADDR, illegal -> ERR.
  - ADDR: HTRANS=NONSEQ with registered HADDR/HWRITE/HSIZE. Hold until HREADY=1 is sampled, then -> DATA.
  - DATA: HTRANS=IDLE; HWDATA = latched writedata, held stable. Wait for HREADY=1; on that edge capture HRDATA and HRESP, then -> IDLE.
  - ERR: single cycle -> IDLE.
- Read completion:
  - readdatavalid pulses for exactly one cycle, the cycle after DATA sees HREADY=1. readdata = HRDATA; response = HRESP ? 10 : 00.
  - The same cycle is IDLE, so back-to-back accept is allowed.
  - Illegal read: readdatavalid pulses the cycle after ERR, with readdata=0 and response=10.
- Write completion: no Avalon-side indication. AHB errors on writes are dropped; illegal writes are discarded.
- AHB two-cycle error (HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1): the bridge keeps waiting in DATA and reports on the HREADY=1 cycle. HTRANS is already IDLE, so no cancel is needed.
- Minimum latency with zero-wait AHB: accept at N, address phase N+1, data phase N+2, readdatavalid N+3.
- Asserting reset mid-transfer abandons the transfer immediately. HTRANS=00 asynchronously and no readdatavalid is issued.

Optional Feature:
- Macro: AVL_AHB_BRIDGE_WRSP_EN.
- With the macro: adds output writeresponsevalid (1 bit, reset 0). It pulses for one cycle on the same schedule as readdatavalid for writes, with response = HRESP ? 10 : 00 (10 for illegal writes). readdata is unchanged on writes.
- Without the macro: the port is absent and writes are posted as described above.

Test Plan:
- Word read at 0x0000_1004, be=1111, HREADY=1 throughout, HRDATA=0xDEADBEEF -> HADDR=0x1004, HSIZE=2, HTRANS=10 for one cycle; readdatavalid at N+3 with 0xDEADBEEF and response=00.
- Byte write at 0x2000, be=0100, writedata=0x00AB0000, with the slave inserting 2 HREADY=0 data cycles -> HADDR=0x2002, HSIZE=0, HWRITE=1; HWDATA=0x00AB0000 held through the waits; waitrequest=1 until the return to IDLE.
- Half read at 0x3000, be=1100, with the slave giving a two-cycle error (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) -> HADDR=0x3002, HSIZE=1; readdatavalid with response=10.
- Read with be=0101, then read and write asserted together -> HTRANS stays 00 for both; the read returns readdatavalid with readdata=0 and response=10; with WRSP_EN, writeresponsevalid also fires with response=10.
- Back-to-back reads at 0x10 and 0x14 -> second accepted in the cycle readdatavalid of the first is high; address phases separated by exactly 3 cycles.
- Reset asserted while in DATA with HREADY=0 -> HTRANS=00, waitrequest=1, readdatavalid=0; after release, a new read at 0x40 completes normally.
